hazard_scoreboard: RTL

- Parametrised hazard and forwarding controller for the in-order pipeline; replaces the fixed 5-stage load-use detector and forwarding pair with one block that tracks DEPTH post-decode stages.
- Holds a shift-register scoreboard of in-flight destination registers and decides ID-stage stalls, per-operand forwarding selects, and front-end flushes.
- Accepts branch/jump redirects from a configurable stage and a hold request from multi-cycle EX units.

---
 rtl/hazard_scoreboard_if.sv | 56 +++++
 rtl/hazard_scoreboard.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard interface: ID-stage operand/destination info, pipeline
// events, and the stall/flush/forward decisions driven back to the datapath.
// Optional performance counters are present when HAZARD_PERF_CNT_EN is defined.
interface hazard_scoreboard_if #(
  parameter int RA_W  = 5,
  parameter int DEPTH = 3
);
  localparam int FW = $clog2(DEPTH + 1);

  logic            id_valid;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic            id_wr_en;
  logic [RA_W-1:0] id_wr_reg;
  logic            id_is_load;
  logic            redirect;
  logic            ex_hold;

  logic             stall;
  logic             flush_if;
  logic             flush_id;
  logic [FW-1:0]    fwd_a;
  logic [FW-1:0]    fwd_b;
  logic [DEPTH-1:0] sb_valid;

`ifdef HAZARD_PERF_CNT_EN
  logic        cnt_clr;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] hold_cnt;
`endif

  // Pipeline control side: supplies instruction info, consumes decisions.
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    output id_wr_en, id_wr_reg, id_is_load, redirect, ex_hold,
`ifdef HAZARD_PERF_CNT_EN
    output cnt_clr,
    input  stall_cnt, flush_cnt, hold_cnt,
`endif
    input  stall, flush_if, flush_id, fwd_a, fwd_b, sb_valid
  );

  // Scoreboard side: consumes instruction info, produces decisions.
  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    input  id_wr_en, id_wr_reg, id_is_load, redirect, ex_hold,
`ifdef HAZARD_PERF_CNT_EN
    input  cnt_clr,
    output stall_cnt, flush_cnt, hold_cnt,
`endif
    output stall, flush_if, flush_id, fwd_a, fwd_b, sb_valid
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shift-register scoreboard of in-flight destination
// registers for DEPTH post-decode stages. Decides ID stalls (load-use and
// multi-cycle EX hold), per-operand forwarding selects, and front-end flushes
// on redirects resolved at entry REDIRECT_STAGE.
// Optional feature macro: HAZARD_PERF_CNT_EN adds stall/flush/hold event
// counters with a cnt_clr input.
module hazard_scoreboard #(
  parameter int RA_W           = 5,
  parameter int DEPTH          = 3,
  parameter int LOAD_STAGE     = 1,
  parameter int REDIRECT_STAGE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_scoreboard_if.slave   bus
);
  localparam int FW = $clog2(DEPTH + 1);

  // Entry i = instruction currently in stage i after ID (0 = EX).
  logic [DEPTH-1:0] ent_v;
  logic [DEPTH-1:0] ent_wr;
  logic [DEPTH-1:0] ent_ld;
  logic [RA_W-1:0]  ent_reg [DEPTH];

  logic [DEPTH-1:0] nxt_v;
  logic [DEPTH-1:0] nxt_wr;
  logic [DEPTH-1:0] nxt_ld;
  logic [RA_W-1:0]  nxt_reg [DEPTH];

  logic [FW-1:0] fwd_a_c;
  logic [FW-1:0] fwd_b_c;
  logic          ld_hit_a;
  logic          ld_hit_b;
  logic          load_stall;
  logic          ev_redirect;
  logic          ev_hold;
  logic          ev_load;

  // Find the youngest producer of each source operand; scanning from the
  // oldest entry down lets the lowest matching index overwrite older hits.
  always_comb begin
    fwd_a_c  = '0;
    fwd_b_c  = '0;
    ld_hit_a = 1'b0;
    ld_hit_b = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_v[i] && ent_wr[i] && (ent_reg[i] == bus.id_rs) &&
          (bus.id_rs != '0) && bus.id_use_rs) begin
        fwd_a_c  = FW'(i + 1);
        ld_hit_a = ent_ld[i] && (i < LOAD_STAGE);
      end
      if (ent_v[i] && ent_wr[i] && (ent_reg[i] == bus.id_rt) &&
          (bus.id_rt != '0) && bus.id_use_rt) begin
        fwd_b_c  = FW'(i + 1);
        ld_hit_b = ent_ld[i] && (i < LOAD_STAGE);
      end
    end
  end

  // Resolve the winning event: redirect beats ex_hold beats load-use.
  always_comb begin
    load_stall  = ld_hit_a || ld_hit_b;
    ev_redirect = bus.redirect;
    ev_hold     = !bus.redirect && bus.ex_hold;
    ev_load     = !bus.redirect && !bus.ex_hold && load_stall;
  end

  assign bus.stall    = ev_hold || ev_load;
  assign bus.flush_if = ev_redirect;
  assign bus.flush_id = ev_redirect;
  assign bus.fwd_a    = fwd_a_c;
  assign bus.fwd_b    = fwd_b_c;
  assign bus.sb_valid = ent_v;

  // Next scoreboard contents for each event; a hold leaves everything as is.
  always_comb begin
    nxt_v   = ent_v;
    nxt_wr  = ent_wr;
    nxt_ld  = ent_ld;
    nxt_reg = ent_reg;
    if (ev_redirect) begin
      // Everything younger than the redirecting entry is wrong-path, so
      // entries 0..REDIRECT_STAGE become bubbles and older ones shift on.
      nxt_v[0]   = 1'b0;
      nxt_wr[0]  = 1'b0;
      nxt_ld[0]  = 1'b0;
      nxt_reg[0] = '0;
      for (int i = 1; i < DEPTH; i++) begin
        if (i <= REDIRECT_STAGE) begin
          nxt_v[i]   = 1'b0;
          nxt_wr[i]  = 1'b0;
          nxt_ld[i]  = 1'b0;
          nxt_reg[i] = '0;
        end else begin
          nxt_v[i]   = ent_v[i-1];
          nxt_wr[i]  = ent_wr[i-1];
          nxt_ld[i]  = ent_ld[i-1];
          nxt_reg[i] = ent_reg[i-1];
        end
      end
    end else if (!ev_hold) begin
      for (int i = 1; i < DEPTH; i++) begin
        nxt_v[i]   = ent_v[i-1];
        nxt_wr[i]  = ent_wr[i-1];
        nxt_ld[i]  = ent_ld[i-1];
        nxt_reg[i] = ent_reg[i-1];
      end
      if (ev_load) begin
        nxt_v[0]   = 1'b0;
        nxt_wr[0]  = 1'b0;
        nxt_ld[0]  = 1'b0;
        nxt_reg[0] = '0;
      end else begin
        nxt_v[0]   = bus.id_valid;
        nxt_wr[0]  = bus.id_wr_en;
        nxt_ld[0]  = bus.id_is_load;
        nxt_reg[0] = bus.id_wr_reg;
      end
    end
  end

  // Scoreboard register; reset wipes every entry regardless of events.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_v  <= '0;
      ent_wr <= '0;
      ent_ld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg[i] <= '0;
      end
    end else begin
      ent_v  <= nxt_v;
      ent_wr <= nxt_wr;
      ent_ld <= nxt_ld;
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg[i] <= nxt_reg[i];
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [31:0] hold_cnt_q;

  // Count cycles won by each event; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      if (ev_load)     stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ev_redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (ev_hold)     hold_cnt_q  <= hold_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
  assign bus.hold_cnt  = hold_cnt_q;
`endif

endmodule
